dvi_video_tx: RTL and testbench
===============================

Name: dvi_video_tx

Overview:
- Synthesizable FPGA-side video output engine that drives the CH7301C DVI transmitter in IDF=3 mode: 8-bit multiplexed RGB555, data latched on both xclk edges.
- Generates the HSYNC/VSYNC/DE timing frame and pulls RGB555 pixels from an upstream pixel source (FIFO or frame-buffer reader) through a ready/valid handshake.
- Splits each pixel into rising- and falling-edge 12-bit halves for external DDR output registers.
- Runs entirely in the pixel clock domain.

Parameters:
- HORI_FRONT_PORCH, 24, pixels from end of DE to next hsync
- HORI_SYNC_PULSE, 136, hsync width in pixels
- HORI_BACK_PORCH, 160, pixels from end of hsync to DE
- HORI_VISIBLE_AREA, 1024, active pixels per line
- VERT_FRONT_PORCH, 3, lines after last visible line before vsync
- VERT_SYNC_PULSE, 6, vsync width in lines
- VERT_BACK_PORCH, 29, lines after vsync before first visible line
- VERT_VISIBLE_AREA, 768, visible lines
- SYNC_POLARITY, 0, 0 = active-low HSYNC/VSYNC, 1 = active-high

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- pixel_data  in  15  {R[14:10], G[9:5], B[4:0]}
- pixel_valid  in  1  source has a pixel
- pixel_ready  out  1  engine consumes a pixel this cycle if pixel_valid
- frame_start  out  1  one-cycle pulse when counters are at h=0, v=0
- underflow  out  1  sticky: a pixel was needed while pixel_valid=0
- dvi_data_rise  out  12  half driven on rising xclk edge
- dvi_data_fall  out  12  half driven on falling xclk edge
- dvi_de  out  1  data enable
- dvi_h  out  1  horizontal sync
- dvi_v  out  1  vertical sync

Behaviour:
- Counters
  - h counts 0..HW-1, where HW = sum of the four HORI_* parameters.
  - v counts 0..VW-1, where VW = sum of the four VERT_* parameters; v increments when h wraps.
  - Counter widths are $clog2(HW) and $clog2(VW). Both wrap to 0 with no gap cycle.
- Vertical region order: sync [0, VSP), back porch [VSP, VSP+VBP), visible [VSP+VBP, VSP+VBP+VVA), front porch (remainder).
- Horizontal region order: sync [0, HSP), back porch [HSP, HSP+HBP), active [HSP+HBP, HSP+HBP+HVA), front porch (remainder).
- Stage-0 decodes, taken from the counters:
  - vs = v in vertical sync, for the whole line.
  - hs = v visible AND h in horizontal sync. There are no hsync pulses on vsync, back-porch or front-porch lines.
  - act = v visible AND h active.
  - At most one of vs, hs, act is true in any cycle.
- Output stage (all registered, latency 1 cycle from counters):
  - dvi_v = vs XNOR SYNC_POLARITY.
  - dvi_h = hs XNOR SYNC_POLARITY.
  - dvi_de = act.
- Handshake:
  - pixel_ready = act (combinational from counters).
  - Transfer occurs when pixel_ready AND pixel_valid; the pixel appears on the data outputs in the next cycle, aligned with dvi_de.
  - The engine never stalls timing.
  - If act AND NOT pixel_valid: output data is 0 for that pixel, and underflow is set and held until rst.
  - pixel_valid outside act is ignored.
- Encoding, with data latched only when act (otherwise both halves are 0):
  - dvi_data_rise = {1'b0, R[4:0], G[4:3], 4'b0}
  - dvi_data_fall = {G[2:0], B[4:0], 4'b0}
- frame_start: registered pulse, asserted in the same cycle dvi_v first asserts for a frame.
- Reset, async assert:
  - h=0, v=0, dvi_de=0, data=0, underflow=0, frame_start=0.
  - dvi_h and dvi_v at their inactive level (1 when SYNC_POLARITY=0).
- After rst deasserts, the first clock edge loads the decodes for (0,0): vsync asserts and frame_start pulses on that edge.
- Reset mid-frame aborts the frame immediately; the next frame restarts from vsync with full timing.
- Pixel accounting:
  - Exactly HVA transfers per visible line and HVA*VVA per frame.
  - A late pixel_valid is not back-filled; the source must realign on frame_start.

Test Plan (small params: HFP=2, HSP=3, HBP=4, HVA=8, VFP=1, VSP=2, VBP=2, VVA=4; HW=17, VW=9, frame=153 cycles, SYNC_POLARITY=0):
- Release reset, pixel_valid=1 -> frame_start and dvi_v=0 on the first edge. dvi_v low for 34 cycles. dvi_h stays 1 until cycle 68 after vsync start, then low for 3 cycles. dvi_de high cycles 75..82. Next vsync at cycle 153.
- Full frame -> exactly 4 hsync pulses, 4 DE bursts of 8 cycles, 32 pixel transfers. No cycle with more than one of DE, H or V active.
- Pixel 15'h7EAA (R=1F, G=15, B=0A) -> dvi_data_rise=12'h7E0, dvi_data_fall=12'hAA0 in the cycle after transfer, with dvi_de=1.
- Drop pixel_valid for 1 cycle mid-line -> that pixel outputs 0/0, underflow=1 thereafter. Timing is unchanged and the remaining 7 pixels transfer.
- SYNC_POLARITY=1 -> dvi_h and dvi_v are 0 at reset and idle, and pulse high with the same widths.
- Assert rst at cycle 100 -> outputs go to reset values asynchronously. After release, vsync restarts and underflow clears.

Source files
------------

// File: rtl/dvi_video_tx.sv
// Video timing and pixel engine for a CH7301C DVI transmitter in IDF=3 mode.
// Produces registered HSYNC/VSYNC/DE and splits RGB555 into rise/fall DDR halves.
module dvi_video_tx #(
  parameter int unsigned HORI_FRONT_PORCH  = 24,
  parameter int unsigned HORI_SYNC_PULSE   = 136,
  parameter int unsigned HORI_BACK_PORCH   = 160,
  parameter int unsigned HORI_VISIBLE_AREA = 1024,
  parameter int unsigned VERT_FRONT_PORCH  = 3,
  parameter int unsigned VERT_SYNC_PULSE   = 6,
  parameter int unsigned VERT_BACK_PORCH   = 29,
  parameter int unsigned VERT_VISIBLE_AREA = 768,
  parameter bit          SYNC_POLARITY     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        frame_start,
  output logic        underflow,
  output logic [11:0] dvi_data_rise,
  output logic [11:0] dvi_data_fall,
  output logic        dvi_de,
  output logic        dvi_h,
  output logic        dvi_v
);

  localparam int unsigned HW = HORI_FRONT_PORCH + HORI_SYNC_PULSE + HORI_BACK_PORCH +
                               HORI_VISIBLE_AREA;
  localparam int unsigned VW = VERT_FRONT_PORCH + VERT_SYNC_PULSE + VERT_BACK_PORCH +
                               VERT_VISIBLE_AREA;
  localparam int unsigned HB = $clog2(HW);
  localparam int unsigned VB = $clog2(VW);

  localparam logic [HB-1:0] HLast     = HB'(HW - 1);
  localparam logic [HB-1:0] HSyncEnd  = HB'(HORI_SYNC_PULSE);
  localparam logic [HB-1:0] HActStart = HB'(HORI_SYNC_PULSE + HORI_BACK_PORCH);
  localparam logic [HB-1:0] HActEnd   = HB'(HORI_SYNC_PULSE + HORI_BACK_PORCH +
                                            HORI_VISIBLE_AREA);
  localparam logic [VB-1:0] VLast     = VB'(VW - 1);
  localparam logic [VB-1:0] VSyncEnd  = VB'(VERT_SYNC_PULSE);
  localparam logic [VB-1:0] VVisStart = VB'(VERT_SYNC_PULSE + VERT_BACK_PORCH);
  localparam logic [VB-1:0] VVisEnd   = VB'(VERT_SYNC_PULSE + VERT_BACK_PORCH +
                                            VERT_VISIBLE_AREA);

  logic [HB-1:0] h_q;
  logic [VB-1:0] v_q;
  logic          v_vis, vs, hs, act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HLast) begin
      h_q <= '0;
      v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  // Sync and active regions are mutually exclusive: hsync only on visible lines.
  always_comb begin
    v_vis = (v_q >= VVisStart) && (v_q < VVisEnd);
    vs    = (v_q < VSyncEnd);
    hs    = v_vis && (h_q < HSyncEnd);
    act   = v_vis && (h_q >= HActStart) && (h_q < HActEnd);
  end

  assign pixel_ready = act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvi_v         <= ~SYNC_POLARITY;
      dvi_h         <= ~SYNC_POLARITY;
      dvi_de        <= 1'b0;
      frame_start   <= 1'b0;
      underflow     <= 1'b0;
      dvi_data_rise <= '0;
      dvi_data_fall <= '0;
    end else begin
      dvi_v       <= ~(vs ^ SYNC_POLARITY);
      dvi_h       <= ~(hs ^ SYNC_POLARITY);
      dvi_de      <= act;
      frame_start <= (h_q == '0) && (v_q == '0);
      underflow   <= underflow | (act & ~pixel_valid);
      // A missing pixel is output as black; timing never waits for the source.
      if (act && pixel_valid) begin
        dvi_data_rise <= {1'b0, pixel_data[14:10], pixel_data[9:8], 4'b0000};
        dvi_data_fall <= {pixel_data[7:5], pixel_data[4:0], 4'b0000};
      end else begin
        dvi_data_rise <= '0;
        dvi_data_fall <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dvi_video_tx.sv
// Directed bench for dvi_video_tx using a 17x9 timing with both sync polarities.
module tb_dvi_video_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] pixel_data = '0;
  logic        pixel_valid = 1'b1;

  logic        pixel_ready, frame_start, underflow, dvi_de, dvi_h, dvi_v;
  logic [11:0] dvi_data_rise, dvi_data_fall;
  logic        pixel_ready2, frame_start2, underflow2, dvi_de2, dvi_h2, dvi_v2;
  logic [11:0] dvi_data_rise2, dvi_data_fall2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dvi_video_tx #(
    .HORI_FRONT_PORCH(2), .HORI_SYNC_PULSE(3), .HORI_BACK_PORCH(4), .HORI_VISIBLE_AREA(8),
    .VERT_FRONT_PORCH(1), .VERT_SYNC_PULSE(2), .VERT_BACK_PORCH(2), .VERT_VISIBLE_AREA(4),
    .SYNC_POLARITY(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .frame_start(frame_start), .underflow(underflow),
    .dvi_data_rise(dvi_data_rise), .dvi_data_fall(dvi_data_fall),
    .dvi_de(dvi_de), .dvi_h(dvi_h), .dvi_v(dvi_v)
  );

  dvi_video_tx #(
    .HORI_FRONT_PORCH(2), .HORI_SYNC_PULSE(3), .HORI_BACK_PORCH(4), .HORI_VISIBLE_AREA(8),
    .VERT_FRONT_PORCH(1), .VERT_SYNC_PULSE(2), .VERT_BACK_PORCH(2), .VERT_VISIBLE_AREA(4),
    .SYNC_POLARITY(1'b1)
  ) dut_pos (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready2), .frame_start(frame_start2), .underflow(underflow2),
    .dvi_data_rise(dvi_data_rise2), .dvi_data_fall(dvi_data_fall2),
    .dvi_de(dvi_de2), .dvi_h(dvi_h2), .dvi_v(dvi_v2)
  );

  task automatic test_reset();
    checks++;
    if ({dvi_de, frame_start, underflow, dvi_data_rise, dvi_data_fall} !== '0) begin
      failures++;
      $display("FAIL reset_zero de=%b fs=%b uf=%b rise=%h fall=%h required all 0",
               dvi_de, frame_start, underflow, dvi_data_rise, dvi_data_fall);
    end
    checks++;
    if ({dvi_h, dvi_v} !== 2'b11) begin
      failures++;
      $display("FAIL reset_sync_neg h=%b v=%b required 1 1", dvi_h, dvi_v);
    end
    checks++;
    if ({dvi_h2, dvi_v2, pixel_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_sync_pos h=%b v=%b ready=%b required 0 0 0", dvi_h2, dvi_v2,
               pixel_ready);
    end
  endtask

  // Releases reset and walks one full frame plus the first cycle of the next.
  task automatic test_frame_timing();
    int v_low = 0, h_low = 0, h_first = -1, h_pulses = 0, de_cnt = 0, de_first = -1;
    int de_last = -1, xfers = 0, multi = 0, fs_cnt = 0, v2_high = 0, h2_high = 0;
    logic h_prev = 1'b1;
    rst = 1'b0;
    pixel_valid = 1'b1;
    for (int e = 0; e <= 153; e++) begin
      @(negedge clk);
      if (e == 0) begin
        checks++;
        if (frame_start !== 1'b1 || dvi_v !== 1'b0) begin
          failures++;
          $display("FAIL first_edge fs=%b v=%b required 1 0", frame_start, dvi_v);
        end
      end
      if (e == 153) begin
        checks++;
        if (frame_start !== 1'b1 || dvi_v !== 1'b0) begin
          failures++;
          $display("FAIL next_vsync fs=%b v=%b required 1 0 at cycle 153", frame_start, dvi_v);
        end
      end else begin
        if (dvi_v === 1'b0) v_low++;
        if (dvi_h === 1'b0) begin
          h_low++;
          if (h_first < 0) h_first = e;
          if (h_prev === 1'b1) h_pulses++;
        end
        h_prev = dvi_h;
        if (dvi_de === 1'b1) begin
          de_cnt++;
          if (de_first < 0) de_first = e;
          if (de_first == 75) de_last = (e <= 82) ? e : de_last;
        end
        if ((dvi_de === 1'b1) + (dvi_h === 1'b0) + (dvi_v === 1'b0) > 1) multi++;
        if (pixel_ready && pixel_valid) xfers++;
        if (frame_start === 1'b1) fs_cnt++;
        if (dvi_v2 === 1'b1) v2_high++;
        if (dvi_h2 === 1'b1) h2_high++;
      end
    end
    checks++;
    if (v_low != 34) begin
      failures++;
      $display("FAIL vsync_width got=%0d required 34", v_low);
    end
    checks++;
    if (h_first != 68) begin
      failures++;
      $display("FAIL hsync_first got=%0d required 68", h_first);
    end
    checks++;
    if (h_low != 12 || h_pulses != 4) begin
      failures++;
      $display("FAIL hsync_count low=%0d pulses=%0d required 12 4", h_low, h_pulses);
    end
    checks++;
    if (de_first != 75 || de_last != 82 || de_cnt != 32) begin
      failures++;
      $display("FAIL de_window first=%0d last=%0d total=%0d required 75 82 32",
               de_first, de_last, de_cnt);
    end
    checks++;
    if (xfers != 32) begin
      failures++;
      $display("FAIL transfers got=%0d required 32", xfers);
    end
    checks++;
    if (multi != 0) begin
      failures++;
      $display("FAIL exclusive overlaps=%0d required 0", multi);
    end
    checks++;
    if (fs_cnt != 1) begin
      failures++;
      $display("FAIL frame_start_count got=%0d required 1", fs_cnt);
    end
    checks++;
    if (v2_high != 34 || h2_high != 12) begin
      failures++;
      $display("FAIL pos_polarity v_high=%0d h_high=%0d required 34 12", v2_high, h2_high);
    end
  endtask

  task automatic wait_line_start(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (pixel_ready === 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (pixel_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      ok = 1'b0;
      failures++;
      $display("FAIL line_start_timeout ready=%b required 1 within 200 cycles", pixel_ready);
    end
  endtask

  task automatic test_encoding();
    logic [14:0] px [4] = '{15'h7EAA, 15'h0400, 15'h7FFF, 15'h001F};
    logic [11:0] er [4] = '{12'h7E0, 12'h040, 12'h7F0, 12'h000};
    logic [11:0] ef [4] = '{12'hAA0, 12'h000, 12'hFF0, 12'h1F0};
    bit ok;
    checks++;
    wait_line_start(ok);
    if (!ok) return;
    for (int i = 0; i < 4; i++) begin
      pixel_data = px[i];
      pixel_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (dvi_data_rise !== er[i] || dvi_data_fall !== ef[i] || dvi_de !== 1'b1) begin
        failures++;
        $display("FAIL encode[%0d] rise=%h fall=%h de=%b required %h %h 1",
                 i, dvi_data_rise, dvi_data_fall, dvi_de, er[i], ef[i]);
      end
    end
    pixel_data = 15'h7FFF;
  endtask

  task automatic test_underflow();
    int xfers = 0;
    bit ok;
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear got=%b required 0", underflow);
    end
    checks++;
    wait_line_start(ok);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      pixel_valid = (i != 2);
      if (pixel_ready && pixel_valid) xfers++;
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (dvi_data_rise !== 12'h000 || dvi_data_fall !== 12'h000 || dvi_de !== 1'b1 ||
            underflow !== 1'b1) begin
          failures++;
          $display("FAIL dropped_pixel rise=%h fall=%h de=%b uf=%b required 000 000 1 1",
                   dvi_data_rise, dvi_data_fall, dvi_de, underflow);
        end
      end
    end
    pixel_valid = 1'b1;
    checks++;
    if (xfers != 7 || dvi_de !== 1'b1 || pixel_ready !== 1'b0) begin
      failures++;
      $display("FAIL after_drop xfers=%0d de=%b ready=%b required 7 1 0", xfers, dvi_de,
               pixel_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky got=%b required 1", underflow);
    end
  endtask

  task automatic test_midframe_reset();
    int n = 0, v_low = 0;
    while (frame_start !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL frame_start_timeout fs=%b required 1 within 400 cycles", frame_start);
      return;
    end
    // Land inside the DE burst of line 5 so the asynchronous clear is visible.
    repeat (76) @(negedge clk);
    checks++;
    if (dvi_de !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_de got=%b required 1", dvi_de);
    end
    repeat (24) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (underflow !== 1'b0 || {dvi_h, dvi_v} !== 2'b11 || {dvi_h2, dvi_v2} !== 2'b00 ||
        dvi_de !== 1'b0 || dvi_data_rise !== 12'h0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset uf=%b h=%b v=%b h2=%b v2=%b de=%b rise=%h required 0 1 1 0 0 0 0",
               underflow, dvi_h, dvi_v, dvi_h2, dvi_v2, dvi_de, dvi_data_rise);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (e == 0) begin
        checks++;
        if (frame_start !== 1'b1 || dvi_v !== 1'b0 || underflow !== 1'b0) begin
          failures++;
          $display("FAIL restart fs=%b v=%b uf=%b required 1 0 0", frame_start, dvi_v, underflow);
        end
      end
      if (dvi_v === 1'b0) v_low++;
    end
    checks++;
    if (v_low != 34) begin
      failures++;
      $display("FAIL restart_vsync_width got=%0d required 34", v_low);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame_timing();
    test_encoding();
    test_underflow();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
